// File: rtl/cnn_sched.sv
// Control sequencer for the CNN datapath: turns the input burst into buffer write
// strobes, then walks conv -> post -> output through start/done handshakes.
module cnn_sched #(
    parameter int IMG_CNT = 48,
    parameter int KER_CNT = 27,
    parameter int WGT_CNT = 4,
    parameter int OUT_CNT = 4,
    localparam int IW = (IMG_CNT > 1) ? $clog2(IMG_CNT) : 1,
    localparam int KW = (KER_CNT > 1) ? $clog2(KER_CNT) : 1,
    localparam int WW = (WGT_CNT > 1) ? $clog2(WGT_CNT) : 1,
    localparam int OW = (OUT_CNT > 1) ? $clog2(OUT_CNT) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [1:0]    opt_in,
    input  logic          conv_done,
    input  logic          post_done,
    output logic          img_we,
    output logic [IW-1:0] img_addr,
    output logic          ker_we,
    output logic [KW-1:0] ker_addr,
    output logic          wgt_we,
    output logic [WW-1:0] wgt_addr,
    output logic [1:0]    opt_q,
    output logic          conv_start,
    output logic          post_start,
    output logic          out_valid,
    output logic [OW-1:0] out_idx,
    output logic          busy
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CONV_WAIT, S_POST_WAIT, S_OUT} state_t;

    localparam logic [IW-1:0] IMG_LAST = IW'(IMG_CNT - 1);
    localparam logic [IW-1:0] KER_LIM  = IW'(KER_CNT);
    localparam logic [IW-1:0] WGT_LIM  = IW'(WGT_CNT);
    localparam logic [OW-1:0] OUT_LAST = OW'(OUT_CNT - 1);

    state_t        r_state, w_state_nx;
    logic [IW-1:0] r_cnt, w_cnt_nx;
    logic          r_started, w_started_nx;
    logic [1:0]    r_opt, w_opt_nx;
    logic          r_img_we, w_img_we_nx;
    logic [IW-1:0] r_img_addr, w_img_addr_nx;
    logic          r_ker_we, w_ker_we_nx;
    logic [KW-1:0] r_ker_addr, w_ker_addr_nx;
    logic          r_wgt_we, w_wgt_we_nx;
    logic [WW-1:0] r_wgt_addr, w_wgt_addr_nx;
    logic          r_conv_start, w_conv_start_nx;
    logic          r_post_start, w_post_start_nx;
    logic          r_out_valid, w_out_valid_nx;
    logic [OW-1:0] r_out_idx, w_out_idx_nx;
    logic          w_acc;
    logic [IW-1:0] w_k;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_started    <= 1'b0;
            r_opt        <= '0;
            r_img_we     <= 1'b0;
            r_img_addr   <= '0;
            r_ker_we     <= 1'b0;
            r_ker_addr   <= '0;
            r_wgt_we     <= 1'b0;
            r_wgt_addr   <= '0;
            r_conv_start <= 1'b0;
            r_post_start <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_idx    <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_cnt        <= w_cnt_nx;
            r_started    <= w_started_nx;
            r_opt        <= w_opt_nx;
            r_img_we     <= w_img_we_nx;
            r_img_addr   <= w_img_addr_nx;
            r_ker_we     <= w_ker_we_nx;
            r_ker_addr   <= w_ker_addr_nx;
            r_wgt_we     <= w_wgt_we_nx;
            r_wgt_addr   <= w_wgt_addr_nx;
            r_conv_start <= w_conv_start_nx;
            r_post_start <= w_post_start_nx;
            r_out_valid  <= w_out_valid_nx;
            r_out_idx    <= w_out_idx_nx;
        end
    end

    always_comb begin
        w_state_nx      = r_state;
        w_cnt_nx        = r_cnt;
        w_started_nx    = r_started;
        w_opt_nx        = r_opt;
        w_conv_start_nx = 1'b0;
        w_post_start_nx = 1'b0;
        w_out_valid_nx  = 1'b0;
        w_out_idx_nx    = '0;
        w_acc           = 1'b0;
        w_k             = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_acc      = 1'b1;
                    w_k        = '0;
                    w_opt_nx   = opt_in;
                    w_cnt_nx   = IW'(1);
                    w_state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    w_acc = 1'b1;
                    if (r_cnt == IMG_LAST) begin
                        w_started_nx = 1'b0;
                        w_state_nx   = S_CONV_WAIT;
                    end else begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end
            end
            S_CONV_WAIT: begin
                // First cycle here fires conv_start; done is only honoured once that pulse is gone.
                if (!r_started) begin
                    w_conv_start_nx = 1'b1;
                    w_started_nx    = 1'b1;
                end else if (!r_conv_start && conv_done) begin
                    w_post_start_nx = 1'b1;
                    w_state_nx      = S_POST_WAIT;
                end
            end
            S_POST_WAIT: begin
                if (!r_post_start && post_done) begin
                    w_out_valid_nx = 1'b1;
                    w_state_nx     = S_OUT;
                end
            end
            S_OUT: begin
                if (r_out_idx == OUT_LAST) begin
                    w_cnt_nx     = '0;
                    w_started_nx = 1'b0;
                    w_state_nx   = S_IDLE;
                end else begin
                    w_out_valid_nx = 1'b1;
                    w_out_idx_nx   = r_out_idx + 1'b1;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase

        w_img_we_nx   = w_acc;
        w_img_addr_nx = w_acc ? w_k : '0;
        w_ker_we_nx   = w_acc && (w_k < KER_LIM);
        w_ker_addr_nx = w_ker_we_nx ? w_k[KW-1:0] : '0;
        w_wgt_we_nx   = w_acc && (w_k < WGT_LIM);
        w_wgt_addr_nx = w_wgt_we_nx ? w_k[WW-1:0] : '0;
    end

    assign img_we     = r_img_we;
    assign img_addr   = r_img_addr;
    assign ker_we     = r_ker_we;
    assign ker_addr   = r_ker_addr;
    assign wgt_we     = r_wgt_we;
    assign wgt_addr   = r_wgt_addr;
    assign opt_q      = r_opt;
    assign conv_start = r_conv_start;
    assign post_start = r_post_start;
    assign out_valid  = r_out_valid;
    assign out_idx    = r_out_idx;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: doc/cnn_sched.md
Name: cnn_sched

Overview:
- Control sequencer for the CNN datapath. It accepts the pattern-side input stream handshake (in_valid plus Opt) and turns it into write strobes and addresses for the image, kernel and weight buffers.
- It then runs the conv and post-processing stages (pooling/FC/activation) through start/done handshakes and drives out_valid and the output index.
- The datapath owns all arithmetic. This block owns only sequencing.

Parameters:
- IMG_CNT, 48, image words per pattern; equals the length of the in_valid burst.
- KER_CNT, 27, kernel words per pattern; carried on the first KER_CNT accepted words.
- WGT_CNT, 4, weight words per pattern; carried on the first WGT_CNT accepted words.
- OUT_CNT, 4, number of output words; out_valid stays high this many consecutive cycles.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid (Img/Kernel/Weight/Opt).
- opt_in  in  2  Opt; sampled only on the first accepted word.
- conv_done  in  1  datapath conv stage finished; single-cycle pulse.
- post_done  in  1  datapath post stage finished; single-cycle pulse.
- img_we  out  1  image buffer write enable.
- img_addr  out  clog2(IMG_CNT)  image buffer write address.
- ker_we  out  1  kernel buffer write enable.
- ker_addr  out  clog2(KER_CNT)  kernel buffer write address.
- wgt_we  out  1  weight buffer write enable.
- wgt_addr  out  clog2(WGT_CNT)  weight buffer write address.
- opt_q  out  2  latched Opt; held until the next pattern's first word.
- conv_start  out  1  one-cycle pulse starting conv.
- post_start  out  1  one-cycle pulse starting post stage.
- out_valid  out  1  output word valid.
- out_idx  out  clog2(OUT_CNT)  index of the current output word.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-high on rst. While rst=1 at an edge: state=IDLE, all counters=0, every output=0 (opt_q included). This applies mid-operation too: no partial pattern survives, and the next in_valid begins a fresh pattern.
- States: IDLE, LOAD, CONV_WAIT, POST_WAIT, OUT.
- IDLE: in_valid=1 counts as accept #0. opt_q<=opt_in; go to LOAD; in_cnt<=1.
- LOAD: each in_valid=1 cycle is one accept; in_cnt increments.
  - in_valid=0 inside LOAD is a gap: count is held and no strobes are issued. The burst resumes when in_valid returns.
  - When accept #IMG_CNT-1 occurs, go to CONV_WAIT.
- Strobe timing: all strobes are registered, one cycle after the accept. The datapath registers Img/Kernel/Weight once, so data and strobe align.
  - Accept #k at cycle t gives, at t+1: img_we=1, img_addr=k.
  - ker_we=1, ker_addr=k only if k<KER_CNT.
  - wgt_we=1, wgt_addr=k only if k<WGT_CNT.
- conv_start: exactly one cycle, at t_last+2, where t_last is the cycle of accept #IMG_CNT-1. That is the cycle after the final img_we.
- CONV_WAIT: conv_done is ignored on the conv_start cycle and earlier, and honoured from t_last+3 onward. conv_done=1 produces a post_start pulse the next cycle and a move to POST_WAIT.
- POST_WAIT: post_done is ignored on the post_start cycle. On post_done=1, go to OUT. The first out_valid appears the cycle after post_done.
- OUT: out_valid=1 for exactly OUT_CNT consecutive cycles, with out_idx=0..OUT_CNT-1. After the last one, out_valid=0 and out_idx=0, and the state returns to IDLE.
- Ignored inputs:
  - in_valid in CONV_WAIT, POST_WAIT and OUT: no strobes, no counting.
  - conv_done/post_done outside their wait state.
- Back-to-back patterns: in_valid may rise in the first IDLE cycle after the last out_valid. It is accepted as word #0 that same cycle.
- No timeouts. The wait states hold indefinitely until the matching done arrives.
- Counters saturate at their terminal counts and never wrap inside a pattern. All counters clear on return to IDLE.

Test Plan:
- Reset then 48-cycle unbroken burst, opt_in=2'd2 on word 0:
  - 48 img_we pulses, addresses 0..47, starting one cycle after the first in_valid.
  - 27 ker_we and 4 wgt_we pulses; opt_q=2.
  - conv_start one cycle after img_addr=47.
- Burst with in_valid=0 for 3 cycles after word 10: img_addr sequence stays contiguous 0..47 with a 3-cycle hole in img_we; conv_start delayed by 3 cycles.
- conv_done pulsed on the conv_start cycle, then 5 cycles later: the first pulse is ignored; post_start occurs exactly one cycle after the second.
- post_done pulse: out_valid high for 4 cycles with out_idx 0,1,2,3; busy falls on the cycle after out_idx=3.
- rst asserted for 1 cycle during word 20 of a burst, then a fresh 48-word burst: all outputs 0 the cycle after rst; the new pattern starts at img_addr=0 with the new opt_q.
- Back-to-back patterns: in_valid rises in the first cycle after the last out_valid; accepted as word #0, opt_q updated, no lost words.
